// File: rtl/hazard_sequencer.sv
// hazard_sequencer: level-1 hazard scheduler (pits, spike trap, death/finish) stepped once per frame
//
// Ports:
//   ClkPort        system clock
//   Reset          asynchronous active-high reset
//   frame_tick     one-cycle pulse per frame; all game timing advances on it
//   start          level start / respawn request (level-sensitive)
//   x_pos, y_pos   player left x and bottom y in pixels
//   level_1_begin .. death   registered one-hot state flags
//   pit1_w, pit2_w current pit widths
//   death_pulse    one-cycle pulse on entry to the death state
//
// Optional macro HAZARD_CHECKPOINT_EN: respawn from the last checkpoint reached
// (INIT, PIT_OPENED_1 or PIT_OPENED_2) instead of always from INIT.
module hazard_sequencer #(
    parameter int TRIG1_X      = 150,
    parameter int PIT1_X       = 200,
    parameter int TRIG2_X      = 300,
    parameter int PIT2_X       = 360,
    parameter int PIT_W        = 64,
    parameter int PIT_STEP     = 4,
    parameter int SPIKE_TRIG_X = 460,
    parameter int SPIKE_X      = 500,
    parameter int SPIKE_W      = 40,
    parameter int SPIKE_DOWN   = 60,
    parameter int SPIKE_UP     = 30,
    parameter int FINISH_X     = 600,
    parameter int GROUND_Y     = 400
) (
    input  logic       ClkPort,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    output logic       level_1_begin,
    output logic       init_1,
    output logic       pit_opening_1,
    output logic       pit_opened_1,
    output logic       pit_opening_2,
    output logic       pit_opened_2,
    output logic       spikes,
    output logic       spikes_opened,
    output logic       done,
    output logic       death,
    output logic [6:0] pit1_w,
    output logic [6:0] pit2_w,
    output logic       death_pulse
);
    // One-hot encoding so the state register bits are the flag outputs directly.
    typedef enum logic [9:0] {
        S_BEGIN  = 10'b00_0000_0001,
        S_INIT   = 10'b00_0000_0010,
        S_PO1    = 10'b00_0000_0100,
        S_PD1    = 10'b00_0000_1000,
        S_PO2    = 10'b00_0001_0000,
        S_PD2    = 10'b00_0010_0000,
        S_SPIKES = 10'b00_0100_0000,
        S_SO     = 10'b00_1000_0000,
        S_DONE   = 10'b01_0000_0000,
        S_DEATH  = 10'b10_0000_0000
    } state_t;

    state_t      state;
    logic [9:0]  flags;
    logic [7:0]  cnt;
    logic [10:0] x11;
    logic        grounded, hit1, hit2, hit_s, live, finish;
    logic [6:0]  w1_next, w2_next;
`ifdef HAZARD_CHECKPOINT_EN
    state_t      ckpt;
`endif

    assign flags = state;
    assign {death, done, spikes_opened, spikes, pit_opened_2, pit_opening_2,
            pit_opened_1, pit_opening_1, init_1, level_1_begin} = flags;

    // 11-bit compares keep edge+width sums from wrapping.
    assign x11      = {1'b0, x_pos};
    assign grounded = y_pos >= 10'(GROUND_Y);
    assign hit1     = grounded && x11 >= 11'(PIT1_X) && x11 < 11'(PIT1_X) + {4'b0, pit1_w};
    assign hit2     = grounded && x11 >= 11'(PIT2_X) && x11 < 11'(PIT2_X) + {4'b0, pit2_w};
    assign hit_s    = grounded && state == S_SO && x11 >= 11'(SPIKE_X) && x11 < 11'(SPIKE_X + SPIKE_W);
    assign live     = |flags[7:2];
    assign finish   = x_pos >= 10'(FINISH_X);
    assign w1_next  = pit1_w >= 7'(PIT_W - PIT_STEP) ? 7'(PIT_W) : pit1_w + 7'(PIT_STEP);
    assign w2_next  = pit2_w >= 7'(PIT_W - PIT_STEP) ? 7'(PIT_W) : pit2_w + 7'(PIT_STEP);

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state       <= S_BEGIN;
            pit1_w      <= '0;
            pit2_w      <= '0;
            cnt         <= '0;
            death_pulse <= 1'b0;
`ifdef HAZARD_CHECKPOINT_EN
            ckpt        <= S_INIT;
`endif
        end else begin
            death_pulse <= 1'b0;
            if (state == S_BEGIN) begin
                // Level start is accepted on any cycle, tick or not.
                if (start) begin
                    state  <= S_INIT;
                    pit1_w <= '0;
                    pit2_w <= '0;
                    cnt    <= '0;
`ifdef HAZARD_CHECKPOINT_EN
                    ckpt   <= S_INIT;
`endif
                end
            end else if (frame_tick) begin
                // Death outranks every other transition, finish included.
                if (live && (hit1 || hit2 || hit_s)) begin
                    state       <= S_DEATH;
                    death_pulse <= 1'b1;
                end else begin
                    case (state)
                        S_INIT: if (x_pos >= 10'(TRIG1_X)) state <= S_PO1;
                        S_PO1: begin
                            pit1_w <= w1_next;
                            if (w1_next == 7'(PIT_W)) begin
                                state <= S_PD1;
`ifdef HAZARD_CHECKPOINT_EN
                                ckpt  <= S_PD1;
`endif
                            end
                        end
                        S_PD1: if (x_pos >= 10'(TRIG2_X)) state <= S_PO2;
                        S_PO2: begin
                            pit2_w <= w2_next;
                            if (w2_next == 7'(PIT_W)) begin
                                state <= S_PD2;
`ifdef HAZARD_CHECKPOINT_EN
                                ckpt  <= S_PD2;
`endif
                            end
                        end
                        S_PD2: begin
                            if (x_pos >= 10'(SPIKE_TRIG_X)) begin
                                state <= S_SPIKES;
                                cnt   <= '0;
                            end
                        end
                        S_SPIKES: begin
                            if (finish) state <= S_DONE;
                            else if (cnt == 8'(SPIKE_DOWN - 1)) begin
                                state <= S_SO;
                                cnt   <= '0;
                            end else cnt <= cnt + 8'd1;
                        end
                        S_SO: begin
                            if (finish) state <= S_DONE;
                            else if (cnt == 8'(SPIKE_UP - 1)) begin
                                state <= S_SPIKES;
                                cnt   <= '0;
                            end else cnt <= cnt + 8'd1;
                        end
                        S_DONE: if (start) state <= S_BEGIN;
                        S_DEATH: begin
                            if (start) begin
                                cnt    <= '0;
`ifdef HAZARD_CHECKPOINT_EN
                                state  <= ckpt;
                                pit1_w <= ckpt == S_INIT ? 7'd0 : 7'(PIT_W);
                                pit2_w <= ckpt == S_PD2 ? 7'(PIT_W) : 7'd0;
`else
                                state  <= S_INIT;
                                pit1_w <= '0;
                                pit2_w <= '0;
`endif
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule
